lcb_responder: RTL and testbench



---
 rtl/lcb_pkg.sv | 34 +++
 rtl/lcb_uart_rx_byte.sv | 124 ++++++++++++
 rtl/lcb_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_lcb_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcb_pkg.sv
// Shared types and UART framing constants for the LCB responder.
// Imported by the byte receiver and the responder top.
package lcb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX_REQ,
      TURN,
      PRE,
      TX_START,
      TX_DATA,
      TX_STOP,
      POST
   } state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rstate_e;

   localparam logic START     = 1'b0;
   localparam logic STOP      = 1'b1;
   localparam int   DATA_BITS = 8;

   // 80 MHz system clock at 5 Mbaud
   localparam int DEF_BIT_CYCLES = 16;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcb_uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, start-bit validation,
// mid-bit sampling and framing-error detection.
module lcb_uart_rx_byte
   import lcb_pkg::*;
#(
   parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   input  logic       en_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       ferr_o,
   output logic       busy_o
);

   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam logic [CW-1:0] HALF_C = CW'(BIT_CYCLES / 2);
   localparam logic [CW-1:0] FULL_C = CW'(BIT_CYCLES);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   // [0] first flop, [1] synchronized rx, [2] previous synchronized rx
   logic [2:0] sync_q;

   rstate_e       st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   logic rxs;
   logic fall;

   assign rxs  = sync_q[1];
   assign fall = sync_q[2] & ~sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= '1;
         st_q    <= R_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], rx_i};
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (!en_i) begin
         st_d  = R_IDLE;
         cnt_d = '0;
      end else begin
         unique case (st_q)
            R_IDLE: begin
               cnt_d = '0;
               if (fall) begin
                  st_d  = R_START;
                  cnt_d = CW'(1);
               end
            end
            R_START: begin
               // a start bit that is high again at mid-bit is a glitch
               if (cnt_q == HALF_C) begin
                  if (rxs == START) begin
                     st_d  = R_DATA;
                     cnt_d = CW'(1);
                     bit_d = '0;
                  end else begin
                     st_d = R_IDLE;
                  end
               end
            end
            R_DATA: begin
               if (cnt_q == FULL_C) begin
                  cnt_d = CW'(1);
                  sh_d  = {rxs, sh_q[7:1]};
                  bit_d = bit_q + 1'b1;
                  if (bit_q == LAST_BIT) begin
                     st_d = R_STOP;
                  end
               end
            end
            R_STOP: begin
               if (cnt_q == FULL_C) begin
                  st_d = R_IDLE;
                  if (rxs == STOP) begin
                     byte_d  = sh_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign byte_o  = byte_q;
   assign valid_o = valid_q;
   assign ferr_o  = ferr_q;
   assign busy_o  = (st_q != R_IDLE);

endmodule

// File: rtl/lcb_responder.sv
// RS-485 LCB slave: receives a fixed-length addressed request and,
// after a turnaround, streams a fixed-length answer from external memory.
module lcb_responder
   import lcb_pkg::*;
#(
   parameter int         BIT_CYCLES  = DEF_BIT_CYCLES,
   parameter int         RQ_BYTES    = 4,
   parameter int         ANS_BYTES   = 16,
   parameter logic [7:0] DEV_ADDR    = 8'h01,
   parameter int         TURN_CYCLES = 64,
   parameter int         GUARD_BITS  = 1,
   parameter int         GAP_BITS    = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   output logic       dirTX,
   output logic       dirRX,
   output logic [7:0] oRqByte,
   output logic       oRqStrobe,
   output logic [7:0] oAddr,
   input  logic [7:0] iData,
   output logic       oBusy,
   output logic       oErr
);

   localparam int GUARD_CYC = GUARD_BITS * BIT_CYCLES;
   localparam int GAP_CYC   = GAP_BITS * BIT_CYCLES;
   // byte reports reach the FSM two cycles after the stop-bit sample
   localparam int TURN_ADJ  = 2;
   localparam int TMR_MAX   = max2(max2(GAP_CYC, TURN_CYCLES),
                                   max2(GUARD_CYC, BIT_CYCLES));

   localparam int TW = $clog2(TMR_MAX + 1);
   localparam int RW = $clog2(RQ_BYTES + 1);
   localparam int AW = $clog2(ANS_BYTES + 1);

   localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_CYCLES - 1);
   localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_CYC - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC);
   localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1 - TURN_ADJ);
   localparam logic [RW-1:0] RQ_LAST    = RW'(RQ_BYTES - 1);
   localparam logic [AW-1:0] ANS_LAST   = AW'(ANS_BYTES - 1);
   localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [RW-1:0] rqc_q, rqc_d;
   logic          ok_q, ok_d;
   logic [7:0]    sh_q, sh_d;
   logic [2:0]    bit_q, bit_d;
   logic [AW-1:0] ans_q, ans_d;
   logic [7:0]    addr_q, addr_d;
   logic          gerr_q, gerr_d;

   logic          rx_en;
   logic [7:0]    rx_byte;
   logic          rx_valid;
   logic          rx_ferr;
   logic          rx_busy;

   logic          first_w;
   logic          ok_w;
   logic [RW-1:0] cnt_w;
   logic          drive_w;

   assign rx_en = (state_q == IDLE) || (state_q == RX_REQ);

   lcb_uart_rx_byte #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .rx_i    (rx),
      .en_i    (rx_en),
      .byte_o  (rx_byte),
      .valid_o (rx_valid),
      .ferr_o  (rx_ferr),
      .busy_o  (rx_busy)
   );

   // the first byte of a request carries the address
   assign first_w = (state_q == IDLE);
   assign ok_w    = first_w ? (rx_byte == DEV_ADDR) : ok_q;
   assign cnt_w   = first_w ? '0 : rqc_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         rqc_q   <= '0;
         ok_q    <= 1'b0;
         sh_q    <= '0;
         bit_q   <= '0;
         ans_q   <= '0;
         addr_q  <= '0;
         gerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         rqc_q   <= rqc_d;
         ok_q    <= ok_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         ans_q   <= ans_d;
         addr_q  <= addr_d;
         gerr_q  <= gerr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      rqc_d   = rqc_q;
      ok_d    = ok_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      ans_d   = ans_q;
      addr_d  = addr_q;
      gerr_d  = 1'b0;
      unique case (state_q)
         IDLE, RX_REQ: begin
            if (rx_valid) begin
               tmr_d = '0;
               ok_d  = ok_w;
               rqc_d = cnt_w + 1'b1;
               if (cnt_w == RQ_LAST) begin
                  state_d = ok_w ? TURN : IDLE;
               end else begin
                  state_d = RX_REQ;
               end
            end else if (state_q == RX_REQ) begin
               if (rx_ferr) begin
                  state_d = IDLE;
               end else if (!rx_busy) begin
                  if (tmr_q == GAP_LAST) begin
                     gerr_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
            end
         end
         TURN: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TURN_LAST) begin
               state_d = PRE;
               tmr_d   = '0;
            end
         end
         PRE: begin
            tmr_d  = tmr_q + 1'b1;
            addr_d = '0;
            if (tmr_q == GUARD_LAST) begin
               state_d = TX_START;
               tmr_d   = '0;
               sh_d    = iData;
               ans_d   = '0;
            end
         end
         TX_START: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == BIT_LAST) begin
               state_d = TX_DATA;
               tmr_d   = '0;
               bit_d   = '0;
            end
         end
         TX_DATA: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == BIT_LAST) begin
               tmr_d = '0;
               sh_d  = sh_q >> 1;
               bit_d = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
                  state_d = TX_STOP;
               end
            end
         end
         TX_STOP: begin
            tmr_d = tmr_q + 1'b1;
            // prefetch the next byte while the stop bit is on the line
            if (tmr_q == '0) begin
               addr_d = addr_q + 1'b1;
            end
            if (tmr_q == BIT_LAST) begin
               tmr_d = '0;
               if (ans_q == ANS_LAST) begin
                  state_d = POST;
               end else begin
                  ans_d   = ans_q + 1'b1;
                  sh_d    = iData;
                  state_d = TX_START;
               end
            end
         end
         POST: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == GUARD_LAST) begin
               state_d = IDLE;
               tmr_d   = '0;
               addr_d  = '0;
            end
         end
      endcase
   end

   assign drive_w = (state_q == PRE) || (state_q == TX_START) ||
                    (state_q == TX_DATA) || (state_q == TX_STOP) ||
                    (state_q == POST);

   assign tx = (state_q == TX_START) ? START :
               (state_q == TX_DATA)  ? sh_q[0] : STOP;

   assign dirTX     = drive_w;
   assign dirRX     = drive_w;
   assign oBusy     = drive_w || (state_q == TURN);
   assign oAddr     = addr_q;
   assign oRqByte   = rx_byte;
   assign oRqStrobe = rx_valid;
   assign oErr      = rx_ferr | gerr_q;

endmodule

// File: tb/tb_lcb_responder.sv
// Directed bench for lcb_responder: request vectors from a table plus
// hand-written framing, gap, glitch, rx-noise and mid-answer reset sequences.
module tb_lcb_responder;

   localparam int BIT = 16;
   localparam int ANS = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] iData = 8'h00;
   logic       tx, dirTX, dirRX, oRqStrobe, oBusy, oErr;
   logic [7:0] oRqByte, oAddr;

   always #5 clk = ~clk;

   lcb_responder dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .tx        (tx),
      .dirTX     (dirTX),
      .dirRX     (dirRX),
      .oRqByte   (oRqByte),
      .oRqStrobe (oRqStrobe),
      .oAddr     (oAddr),
      .iData     (iData),
      .oBusy     (oBusy),
      .oErr      (oErr)
   );

   // answer memory: memory[i] = i, one cycle read latency
   always_ff @(posedge clk) iData <= oAddr;

   int checks = 0;
   int errors = 0;

   int         cyc = 0;
   logic [7:0] rq_q[$];
   logic [7:0] ans_q[$];
   int err_n, err_cyc, last_str, rise_n, rise_cyc, fall_cyc;
   int busy_n, dirmis, txbad, framebad;
   logic       prev_dir = 1'b0;
   logic       prev_tx = 1'b1;
   int         dst = 0;
   int         dcnt = 0;
   int         kbit;
   logic [7:0] dsh = 8'h00;

   // bus monitor with an independent UART decoder for tx
   initial forever begin
      @(negedge clk);
      cyc++;
      if (oRqStrobe === 1'b1) begin
         rq_q.push_back(oRqByte);
         last_str = cyc;
      end
      if (oErr === 1'b1) begin
         err_n++;
         err_cyc = cyc;
      end
      if (dirTX === 1'b1 && prev_dir === 1'b0) begin
         rise_n++;
         rise_cyc = cyc;
      end
      if (dirTX === 1'b0 && prev_dir === 1'b1) fall_cyc = cyc;
      if (oBusy === 1'b1) busy_n++;
      if (dirRX !== dirTX) dirmis++;
      if (dirTX === 1'b0 && tx !== 1'b1) txbad++;
      if (dirTX !== 1'b1) begin
         dst = 0;
      end else if (dst == 0) begin
         if (prev_tx === 1'b1 && tx === 1'b0) begin
            dst = 1;
            dcnt = 0;
         end
      end else begin
         dcnt++;
         if (dcnt == BIT / 2 && tx !== 1'b0) framebad++;
         if (dcnt > BIT / 2 && (dcnt - BIT / 2) % BIT == 0) begin
            kbit = (dcnt - BIT / 2) / BIT;
            if (kbit <= 8) begin
               dsh = {tx, dsh[7:1]};
            end else begin
               if (tx !== 1'b1) framebad++;
               ans_q.push_back(dsh);
               dst = 0;
            end
         end
      end
      prev_dir = dirTX;
      prev_tx = tx;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chkr(input string nm, input int act,
                       input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic clear_mon();
      rq_q.delete();
      ans_q.delete();
      err_n = 0;
      err_cyc = 0;
      last_str = 0;
      rise_n = 0;
      rise_cyc = 0;
      fall_cyc = 0;
      busy_n = 0;
      dirmis = 0;
      txbad = 0;
      framebad = 0;
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      tick(n);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stopv);
      drive(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(b[i], BIT);
      drive(stopv, BIT);
      rx = 1'b1;
   endtask

   task automatic send_req(input logic [3:0][7:0] r);
      for (int i = 0; i < 4; i++) send_byte(r[i], 1'b1);
   endtask

   task automatic wait_dir(input logic lvl, input int budget,
                           input string nm);
      int n;
      n = 0;
      while (dirTX !== lvl && n < budget) begin
         tick(1);
         n++;
      end
      chk(nm, dirTX, lvl);
   endtask

   task automatic verify_req(input string nm, input logic [3:0][7:0] r,
                             input bit ans);
      logic [31:0] got;
      int bad;
      got = '0;
      for (int i = 0; i < rq_q.size() && i < 4; i++) got[8*i +: 8] = rq_q[i];
      chk({nm, "_nstrobe"}, rq_q.size(), 4);
      chk({nm, "_rqbytes"}, got, r);
      chk({nm, "_oerr"}, err_n, 0);
      chk({nm, "_dirrx"}, dirmis, 0);
      chk({nm, "_tx_idle"}, txbad, 0);
      if (ans) begin
         bad = 0;
         for (int i = 0; i < ans_q.size(); i++)
            if (ans_q[i] !== 8'(i)) bad++;
         chk({nm, "_nbytes"}, ans_q.size(), ANS);
         chk({nm, "_badbytes"}, bad, 0);
         chk({nm, "_framing"}, framebad, 0);
         chk({nm, "_turn"}, rise_cyc - last_str, 63);
         chk({nm, "_bustime"}, fall_cyc - rise_cyc, (2 + 10 * ANS) * BIT);
         chkr({nm, "_busy"}, busy_n, (2 + 10 * ANS) * BIT,
              (2 + 10 * ANS) * BIT + 64);
      end else begin
         chk({nm, "_norise"}, rise_n, 0);
         chk({nm, "_nobusy"}, busy_n, 0);
      end
   endtask

   typedef struct {
      logic [3:0][7:0] rq;
      bit              ans;
   } vec_t;

   vec_t tbl[4];
   logic [3:0][7:0] good_rq;
   int g0;
   int n;

   initial begin
      tbl[0].rq = {8'h3C, 8'h5A, 8'hA5, 8'h01}; tbl[0].ans = 1'b1;
      tbl[1].rq = {8'h00, 8'h00, 8'h00, 8'h02}; tbl[1].ans = 1'b0;
      tbl[2].rq = {8'h80, 8'hFF, 8'h00, 8'h01}; tbl[2].ans = 1'b1;
      tbl[3].rq = {8'h01, 8'h01, 8'h01, 8'hFF}; tbl[3].ans = 1'b0;
      good_rq = {8'h3C, 8'h5A, 8'hA5, 8'h01};

      rst = 1'b0;
      rx = 1'b1;
      tick(5);
      chk("rst_tx", tx, 1'b1);
      chk("rst_dirtx", dirTX, 1'b0);
      chk("rst_dirrx", dirRX, 1'b0);
      chk("rst_rqbyte", oRqByte, 8'h00);
      chk("rst_strobe", oRqStrobe, 1'b0);
      chk("rst_addr", oAddr, 8'h00);
      chk("rst_busy", oBusy, 1'b0);
      chk("rst_err", oErr, 1'b0);
      rst = 1'b1;
      tick(20);

      for (int v = 0; v < 4; v++) begin
         clear_mon();
         send_req(tbl[v].rq);
         if (tbl[v].ans) begin
            wait_dir(1'b1, 200, $sformatf("vec%0d_rise", v));
            wait_dir(1'b0, 3000, $sformatf("vec%0d_fall", v));
            tick(5);
         end else begin
            tick(300);
         end
         verify_req($sformatf("vec%0d", v), tbl[v].rq, tbl[v].ans);
      end

      // framing error, then recovery
      clear_mon();
      send_byte(8'h01, 1'b0);
      tick(30);
      chk("frm_oerr", err_n, 1);
      chk("frm_nostrobe", rq_q.size(), 0);
      clear_mon();
      send_req(good_rq);
      wait_dir(1'b1, 200, "frm_rise");
      wait_dir(1'b0, 3000, "frm_fall");
      tick(5);
      verify_req("frm_recover", good_rq, 1'b1);

      // inter-byte gap timeout
      clear_mon();
      send_byte(8'h01, 1'b1);
      send_byte(8'hA5, 1'b1);
      g0 = last_str;
      drive(1'b1, 25 * BIT);
      chk("gap_oerr", err_n, 1);
      chkr("gap_time", err_cyc - g0, 20 * BIT, 20 * BIT + 10);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hA5, 1'b1);
      tick(300);
      chk("gap_nstrobe", rq_q.size(), 6);
      chk("gap_byte2", (rq_q.size() > 2) ? rq_q[2] : 8'hXX, 8'h5A);
      chk("gap_norise", rise_n, 0);
      chk("gap_nobusy", busy_n, 0);
      chk("gap_oerr_once", err_n, 1);

      // short low glitch in IDLE
      clear_mon();
      drive(1'b0, 4);
      drive(1'b1, 40);
      chk("glitch_nostrobe", rq_q.size(), 0);
      chk("glitch_noerr", err_n, 0);

      // rx noise during the answer
      clear_mon();
      send_req(good_rq);
      wait_dir(1'b1, 200, "noise_rise");
      for (int i = 0; i < 300; i++) drive(~rx, 3);
      rx = 1'b1;
      wait_dir(1'b0, 3000, "noise_fall");
      tick(5);
      verify_req("noise", good_rq, 1'b1);

      // reset in the middle of answer byte 7
      clear_mon();
      send_req(good_rq);
      wait_dir(1'b1, 200, "mrst_rise");
      n = 0;
      while (ans_q.size() < 7 && n < 2000) begin
         tick(1);
         n++;
      end
      chk("mrst_reach7", ans_q.size(), 7);
      tick(80);
      rst = 1'b0;
      tick(1);
      chk("mrst_tx", tx, 1'b1);
      chk("mrst_dirtx", dirTX, 1'b0);
      chk("mrst_dirrx", dirRX, 1'b0);
      chk("mrst_busy", oBusy, 1'b0);
      chk("mrst_addr", oAddr, 8'h00);
      rst = 1'b1;
      tick(10);
      chk("mrst_nopartial", ans_q.size(), 7);
      clear_mon();
      send_req(good_rq);
      wait_dir(1'b1, 200, "post_rst_rise");
      wait_dir(1'b0, 3000, "post_rst_fall");
      tick(5);
      verify_req("post_rst", good_rq, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
